// File: rtl/tnn_feature_loader.sv
// Serial-to-parallel feature loader wrapping a combinational TNN classifier.
// Packs one feature per handshake, holds the bus to let the classifier settle, then returns the class.
module tnn_feature_loader #(
  parameter int FEAT_CNT      = 19,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_BITS      = 16,
  localparam int PW           = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FEAT_BITS-1:0]          feat_in,
  input  logic                          feat_valid,
  input  logic                          feat_last,
  output logic                          feat_ready,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PW-1:0]                 prediction,
  output logic [PW-1:0]                 pred_out,
  output logic                          pred_valid,
  input  logic                          pred_ready,
  output logic [CNT_BITS-1:0]           frame_cnt,
  output logic                          frame_err
);

  localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(FEAT_CNT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_OUT
  } state_t;

  state_t                        r_state;
  logic [IW-1:0]                 r_idx;
  logic [SW-1:0]                 r_settle;
  logic                          r_feat_ready;
  logic [FEAT_CNT*FEAT_BITS-1:0] r_features;
  logic [PW-1:0]                 r_pred_out;
  logic                          r_pred_valid;
  logic [CNT_BITS-1:0]           r_frame_cnt;
  logic                          r_frame_err;

  // feat_ready is registered alongside the state so it is high exactly in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_idx        <= '0;
      r_settle     <= '0;
      r_feat_ready <= 1'b1;
      r_features   <= '0;
      r_pred_out   <= '0;
      r_pred_valid <= 1'b0;
      r_frame_cnt  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (feat_valid) begin
            r_features[int'(r_idx)*FEAT_BITS +: FEAT_BITS] <= feat_in;
            if (r_idx == IDX_LAST) begin
              r_state      <= S_SETTLE;
              r_idx        <= '0;
              r_settle     <= '0;
              r_feat_ready <= 1'b0;
            end else if (feat_last) begin
              // short frame: drop it, the next frame overwrites the stale slots
              r_frame_err <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle + 1'b1;
          if (r_settle == SETTLE_LAST) begin
            r_pred_out   <= prediction;
            r_pred_valid <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (pred_ready) begin
            r_pred_valid <= 1'b0;
            r_frame_cnt  <= r_frame_cnt + 1'b1;
            r_feat_ready <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        default: begin
          r_state      <= S_LOAD;
          r_feat_ready <= 1'b1;
          r_pred_valid <= 1'b0;
        end
      endcase
    end
  end

  assign feat_ready = r_feat_ready;
  assign features   = r_features;
  assign pred_out   = r_pred_out;
  assign pred_valid = r_pred_valid;
  assign frame_cnt  = r_frame_cnt;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader with a small stand-in classifier (feature sum + 1, mod 3).
module tb_tnn_feature_loader;

  localparam int FC = 19;
  localparam int FB = 4;
  localparam logic [FC*FB-1:0] EXP_BASIC = 76'h210FEDCBA9876543210;
  localparam logic [FC*FB-1:0] EXP_SEVEN = {19{4'h7}};

  logic              clk = 1'b0;
  logic              rst;
  logic [FB-1:0]     feat_in;
  logic              feat_valid;
  logic              feat_last;
  logic              feat_ready;
  logic [FC*FB-1:0]  features;
  logic [1:0]        prediction;
  logic [1:0]        pred_out;
  logic              pred_valid;
  logic              pred_ready;
  logic [15:0]       frame_cnt;
  logic              frame_err;

  int total  = 0;
  int passed = 0;

  tnn_feature_loader #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(3), .SETTLE_CYCLES(2), .CNT_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .feat_in(feat_in), .feat_valid(feat_valid), .feat_last(feat_last),
    .feat_ready(feat_ready), .features(features), .prediction(prediction), .pred_out(pred_out),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model(input logic [FC*FB-1:0] f);
    int s;
    s = 1;
    for (int k = 0; k < FC; k++) s += int'(f[k*FB +: FB]);
    return 2'(s % 3);
  endfunction

  assign prediction = model(features);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [FB-1:0] v, input logic last);
    int n;
    n = 0;
    feat_in = v; feat_last = last; feat_valid = 1'b1;
    while (!feat_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin total++; $display("FAIL send_beat_timeout feat_ready got %b want 1", feat_ready); end
    tick();
    feat_valid = 1'b0; feat_last = 1'b0;
  endtask

  task automatic wait_pv();
    int n;
    n = 0;
    while (!pred_valid && n < 200) begin tick(); n++; end
    if (n >= 200) begin total++; $display("FAIL wait_pred_valid_timeout got %b want 1", pred_valid); end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    feat_in = '0; feat_valid = 1'b0; feat_last = 1'b0; pred_ready = 1'b0;
    do_reset();
    total++; if (features !== '0) $display("FAIL rst_features got %h want 0", features); else passed++;
    total++; if (pred_valid !== 1'b0) $display("FAIL rst_pred_valid got %b want 0", pred_valid); else passed++;
    total++; if (pred_out !== 2'd0) $display("FAIL rst_pred_out got %0d want 0", pred_out); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL rst_feat_ready got %b want 1", feat_ready); else passed++;
  endtask

  task automatic test_basic();
    pred_ready = 1'b1;
    for (int k = 0; k < FC; k++) send_beat(4'(k % 16), k == FC - 1);
    total++; if (pred_valid !== 1'b0) $display("FAIL basic_pv_c1 got %b want 0", pred_valid); else passed++;
    tick();
    total++; if (pred_valid !== 1'b0) $display("FAIL basic_pv_c2 got %b want 0", pred_valid); else passed++;
    tick();
    total++; if (pred_valid !== 1'b1) $display("FAIL basic_pv_c3 got %b want 1", pred_valid); else passed++;
    total++; if (pred_out !== 2'd1) $display("FAIL basic_pred got %0d want 1", pred_out); else passed++;
    total++; if (features !== EXP_BASIC) $display("FAIL basic_features got %h want %h", features, EXP_BASIC); else passed++;
    tick();
    total++; if (pred_valid !== 1'b0) $display("FAIL basic_pv_after got %b want 0", pred_valid); else passed++;
    total++; if (frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL basic_feat_ready got %b want 1", feat_ready); else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    pred_ready = 1'b0;
    for (int k = 0; k < FC; k++) send_beat(4'h7, k == FC - 1);
    wait_pv();
    // junk offered while busy must be ignored
    feat_in = 4'hF; feat_valid = 1'b1; feat_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (pred_valid !== 1'b1 || pred_out !== 2'd2 || feat_ready !== 1'b0 || features !== EXP_SEVEN) bad++;
      tick();
    end
    total++; if (bad != 0) $display("FAIL bp_hold bad_cycles got %0d want 0", bad); else passed++;
    feat_valid = 1'b0; feat_last = 1'b0; pred_ready = 1'b1;
    tick();
    total++; if (pred_valid !== 1'b0) $display("FAIL bp_release_pv got %b want 0", pred_valid); else passed++;
    total++; if (frame_cnt !== 16'd2) $display("FAIL bp_frame_cnt got %0d want 2", frame_cnt); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL bp_feat_ready got %b want 1", feat_ready); else passed++;
    total++; if (features !== EXP_SEVEN) $display("FAIL bp_features got %h want %h", features, EXP_SEVEN); else passed++;
  endtask

  task automatic test_gapped();
    pred_ready = 1'b1;
    for (int k = 0; k < FC; k++) begin
      send_beat(4'(k % 16), k == FC - 1);
      if (k != FC - 1) begin feat_in = 4'hF; tick(); end
    end
    wait_pv();
    total++; if (pred_out !== 2'd1) $display("FAIL gap_pred got %0d want 1", pred_out); else passed++;
    total++; if (features !== EXP_BASIC) $display("FAIL gap_features got %h want %h", features, EXP_BASIC); else passed++;
    tick();
    total++; if (frame_cnt !== 16'd3) $display("FAIL gap_frame_cnt got %0d want 3", frame_cnt); else passed++;
  endtask

  task automatic test_early_last();
    pred_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_beat(4'hF, k == 4);
    total++; if (frame_err !== 1'b1) $display("FAIL early_err got %b want 1", frame_err); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL early_ready got %b want 1", feat_ready); else passed++;
    for (int k = 0; k < FC; k++) send_beat(4'h7, k == FC - 1);
    wait_pv();
    total++; if (pred_out !== 2'd2) $display("FAIL early_next_pred got %0d want 2", pred_out); else passed++;
    total++; if (features !== EXP_SEVEN) $display("FAIL early_next_features got %h want %h", features, EXP_SEVEN); else passed++;
    tick();
    total++; if (frame_cnt !== 16'd4) $display("FAIL early_frame_cnt got %0d want 4", frame_cnt); else passed++;
    total++; if (frame_err !== 1'b1) $display("FAIL early_err_sticky got %b want 1", frame_err); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) send_beat(4'h3, 1'b0);
    feat_in = 4'h3; feat_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; feat_valid = 1'b0;
    total++; if (features !== '0) $display("FAIL rmid_features got %h want 0", features); else passed++;
    total++; if (pred_valid !== 1'b0) $display("FAIL rmid_pv got %b want 0", pred_valid); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL rmid_frame_cnt got %0d want 0", frame_cnt); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", feat_ready); else passed++;
    pred_ready = 1'b0;
    for (int k = 0; k < FC; k++) send_beat(4'h7, k == FC - 1);
    wait_pv();
    total++; if (pred_valid !== 1'b1) $display("FAIL rout_pv_before got %b want 1", pred_valid); else passed++;
    rst = 1'b1; pred_ready = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (features !== '0) $display("FAIL rout_features got %h want 0", features); else passed++;
    total++; if (pred_valid !== 1'b0) $display("FAIL rout_pv got %b want 0", pred_valid); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL rout_frame_cnt got %0d want 0", frame_cnt); else passed++;
    total++; if (feat_ready !== 1'b1) $display("FAIL rout_ready got %b want 1", feat_ready); else passed++;
  endtask

  task automatic test_regression();
    logic [31:0]      seed;
    logic [FC*FB-1:0] vec;
    logic [FB-1:0]    v;
    int               bad;
    logic [1:0]       first_got, first_want;
    seed = 32'h1234_5678; bad = 0; first_got = '0; first_want = '0;
    pred_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < FC; k++) begin
        seed = seed * 32'd1664525 + 32'd1013904223;
        v = seed[27:24];
        vec[k*FB +: FB] = v;
        send_beat(v, k == FC - 1);
      end
      wait_pv();
      if (pred_out !== model(vec)) begin
        if (bad == 0) begin first_got = pred_out; first_want = model(vec); end
        bad++;
      end
      tick();
    end
    total++; if (bad != 0) $display("FAIL regr_preds bad=%0d first got %0d want %0d", bad, first_got, first_want); else passed++;
    total++; if (frame_cnt !== 16'd1000) $display("FAIL regr_frame_cnt got %0d want 1000", frame_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_early_last();
    test_reset_mid();
    test_regression();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tnn_feature_loader.md
# tnn_feature_loader

Upstream/downstream wrapper for the combinational TNN classifier (e.g. the 19-feature, 3-class cardio network). It accepts one quantized feature per handshake from a narrow stream, packs the features into the classifier's flat feature bus, and holds that bus stable while the combinational logic settles. It then latches the classifier's prediction and returns it over a valid/ready handshake. This replaces the testbench's fixed-delay parallel drive with a cycle-accurate, backpressured frame interface.

## Interface
- FEAT_CNT, 19: features per frame.
- FEAT_BITS, 4: bits per feature.
- CLASS_CNT, 3: classifier classes; prediction width PW = $clog2(CLASS_CNT).
- SETTLE_CYCLES, 1: cycles the packed bus is held before the prediction is captured (≥1).
- CNT_BITS, 16: width of the completed-frame counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- feat_in  in  FEAT_BITS  current feature value.
- feat_valid  in  1  feat_in/feat_last valid.
- feat_last  in  1  marks the final feature of a frame.
- feat_ready  out  1  loader accepts a feature this cycle.
- features  out  FEAT_CNT*FEAT_BITS  packed bus to the classifier; feature k occupies bits [k*FEAT_BITS +: FEAT_BITS].
- prediction  in  PW  classifier output (combinational from features).
- pred_out  out  PW  latched class index.
- pred_valid  out  1  pred_out valid.
- pred_ready  in  1  consumer accepts pred_out.
- frame_cnt  out  CNT_BITS  completed (handshaken) predictions, wraps modulo 2^CNT_BITS.
- frame_err  out  1  sticky; an early feat_last was seen.

## Operation
- FSM states: LOAD, SETTLE, OUT. Reset state is LOAD.
- Reset values: features=0, pred_out=0, pred_valid=0, frame_cnt=0, frame_err=0, feature index idx=0, settle counter=0. feat_ready=1 in the first cycle after reset.
- LOAD: feat_ready=1. An accept (feat_valid&feat_ready) writes feat_in into slot idx. Other slots are untouched.
  - If idx<FEAT_CNT-1 and feat_last=0: idx++.
  - If idx<FEAT_CNT-1 and feat_last=1: set frame_err and reset idx to 0. The partial frame is discarded (slots are overwritten by the next frame) and the FSM stays in LOAD.
  - If idx==FEAT_CNT-1: move to SETTLE, reset idx to 0 and the settle counter to 0. feat_last is ignored on this beat.
- SETTLE: feat_ready=0 and features is held constant. The settle counter increments each cycle. On the cycle it equals SETTLE_CYCLES-1: pred_out<=prediction, pred_valid<=1, and the FSM moves to OUT.
- OUT: feat_ready=0, features held, pred_out held. On pred_valid&pred_ready: pred_valid<=0, frame_cnt++, and the FSM moves to LOAD.
- The features register is written only in LOAD. It keeps the last frame's values until they are overwritten.
- frame_err clears only on rst.

## Timing
- The last feature is accepted at edge t. The FSM is in SETTLE during cycles t..t+SETTLE_CYCLES-1. pred_valid is first high in the cycle after edge t+SETTLE_CYCLES.
  - Example, SETTLE_CYCLES=1: last beat in cycle c, pred_valid high in cycle c+2.
- With pred_ready held high, pred_valid lasts exactly 1 cycle and feat_ready returns in the next cycle. Minimum frame period is FEAT_CNT+SETTLE_CYCLES+1 cycles.
- pred_valid, once raised, stays high with pred_out stable until it is accepted (no retraction).
- pred_ready is ignored outside OUT. feat_valid is ignored outside LOAD.
- rst asserted in any state aborts at the next edge and restores the reset values. A frame in progress is lost and frame_cnt is not incremented.
- frame_cnt wraps from 2^CNT_BITS-1 to 0 with no flag.

## Test plan
Default parameters, SETTLE_CYCLES=2 unless noted.
- **Basic frame:** stream features 0..18 valued k%16 with feat_last on k=18, pred_ready=1.
  - features = 0x210FEDCBA9876543210.
  - pred_valid rises 3 cycles after the last beat and pred_out equals the model's prediction.
  - frame_cnt=1.
- **Backpressure:** hold pred_ready=0 for 10 cycles after pred_valid.
  - pred_valid and pred_out stay stable and feat_ready=0 throughout.
  - On release: 1-cycle handshake, then feat_ready=1.
- **Gapped input:** feat_valid toggles 1,0,1,0 across the frame.
  - Only valid beats are stored, and the result equals the gap-free run.
- **Early last:** feat_last on beat 5.
  - frame_err=1 and stays 1.
  - A following full 19-beat frame produces a correct prediction and frame_cnt increments once.
- **Reset mid-frame:** rst during beat 10, then during OUT with pred_valid=1.
  - Both times the next cycle shows features=0, pred_valid=0, frame_cnt unchanged from 0, and feat_ready=1.
- **Regression:** drive the 1000 cardio.memh vectors serially at full rate.
  - The prediction sequence matches the parallel-testbench output.
  - frame_cnt=1000 at the end.
